// File: rtl/dfdd_pkg.sv
// ---------------------------------------------------------------------------
// dfdd_pkg
// Shared types and constants for the dfdd pipeline blocks.
//   fp16_t      : half-precision word (1 sign, 5 exponent, 10 fraction bits)
//   FP_ONE      : fp16 encoding of +1.0
//   seq_state_t : window-sequencer FSM states
// ---------------------------------------------------------------------------
package dfdd_pkg;

  localparam int FP16_EXP_WIDTH  = 5;
  localparam int FP16_FRAC_WIDTH = 10;
  localparam int FP16_WIDTH      = 1 + FP16_EXP_WIDTH + FP16_FRAC_WIDTH;

  typedef logic [FP16_WIDTH-1:0] fp16_t;

  localparam fp16_t FP_ONE = 16'h3C00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_RUN,
    ST_FLUSH
  } seq_state_t;

endpackage

// File: rtl/hwin_credit_counter.sv
// ---------------------------------------------------------------------------
// hwin_credit_counter
// Up/down saturating credit counter. Starts full (CREDITS) out of reset.
// Ports:
//   clk        : clock
//   rst_n      : asynchronous active-low reset
//   inc        : one slot returned by downstream
//   dec        : one slot consumed (window issued)
//   has_credit : at least one slot available
// inc and dec together leave the count unchanged. A return while already
// full saturates and is flagged by an assertion (downstream protocol error).
// ---------------------------------------------------------------------------
module hwin_credit_counter #(
  parameter int CREDITS   = 16,
  parameter int CNT_WIDTH = $clog2(CREDITS + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  output logic has_credit
);

  localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(CREDITS);

  logic [CNT_WIDTH-1:0] count_reg;
  logic [CNT_WIDTH-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (inc && !dec) begin
      if (count_reg != FULL) count_next = count_reg + 1'b1;
    end else if (dec && !inc) begin
      if (count_reg != '0) count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_reg <= FULL;
    else        count_reg <= count_next;
  end

  assign has_credit = (count_reg != '0);

  credit_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(inc && !dec && count_reg == FULL));

endmodule

// File: rtl/hwin_sequencer_fp16.sv
// ---------------------------------------------------------------------------
// hwin_sequencer_fp16
// Raster-order scheduler for the 1xWINDOW_WIDTH horizontal fp convolution.
// Takes one pixel per cycle, keeps a sliding window, pads both row edges and
// issues centred windows tagged with (col,row). Downstream is credit-based
// since the convolution pipeline cannot stall.
//
// Ports:
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   pix_i/pix_valid_i    : input pixel stream
//   pix_ready_o          : pixel accepted when valid & ready
//   credit_i             : one-cycle pulse, one downstream slot freed
//   window_o             : taps, index 0 = leftmost (col - HALF)
//   kernel_o             : constant +1.0 per tap (box filter)
//   col_o, row_o         : centre coordinate of window_o
//   valid_o              : window issued this cycle
//   frame_done_o         : pulses with the last window of the frame
//
// Build option: HWIN_REPLICATE_EDGE_EN -- when defined, pad with the nearest
// edge pixel of the row; otherwise pad with +0.0.
// ---------------------------------------------------------------------------
module hwin_sequencer_fp16
  import dfdd_pkg::*;
#(
  parameter int EXP_WIDTH    = 5,
  parameter int FRAC_WIDTH   = 10,
  parameter int WINDOW_WIDTH = 7,
  parameter int IMG_WIDTH    = 640,
  parameter int IMG_HEIGHT   = 480,
  parameter int CREDITS      = 16,
  localparam int FP_WIDTH    = 1 + EXP_WIDTH + FRAC_WIDTH
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [FP_WIDTH-1:0]                    pix_i,
  input  logic                                   pix_valid_i,
  output logic                                   pix_ready_o,
  input  logic                                   credit_i,
  output logic [WINDOW_WIDTH-1:0][FP_WIDTH-1:0]  window_o,
  output logic [WINDOW_WIDTH-1:0][FP_WIDTH-1:0]  kernel_o,
  output logic [15:0]                            col_o,
  output logic [15:0]                            row_o,
  output logic                                   valid_o,
  output logic                                   frame_done_o
);

  localparam int HALF = WINDOW_WIDTH / 2;
  localparam logic [15:0] HALF_COL = 16'(HALF);
  localparam logic [15:0] LAST_COL = 16'(IMG_WIDTH - 1);
  localparam logic [15:0] LAST_ROW = 16'(IMG_HEIGHT - 1);
  // +1.0: biased exponent 0111..1, zero fraction
  localparam logic [FP_WIDTH-1:0] ONE = {2'b00, {(EXP_WIDTH-1){1'b1}}, {FRAC_WIDTH{1'b0}}};

  typedef logic [WINDOW_WIDTH-1:0][FP_WIDTH-1:0] window_t;

  seq_state_t    state_reg, state_next;
  window_t       taps_reg, taps_next, shifted;
  logic [15:0]   in_col_reg, in_col_next;
  logic [15:0]   out_col_reg, out_col_next;
  logic [15:0]   row_reg, row_next;
  logic [15:0]   col_out_reg, row_out_reg;
  logic          valid_reg, frame_done_reg, ready_en_reg;
  logic          issue, frame_end, accept, has_credit;
  logic [FP_WIDTH-1:0] left_pad, right_pad, shift_in;

`ifdef HWIN_REPLICATE_EDGE_EN
  // Left pad is the first pixel itself; right pad repeats the newest tap,
  // which during flush is always the last pixel of the row.
  assign left_pad  = pix_i;
  assign right_pad = taps_reg[WINDOW_WIDTH-1];
`else
  assign left_pad  = '0;
  assign right_pad = '0;
`endif

  assign shift_in = (state_reg == ST_FLUSH) ? right_pad : pix_i;

  for (genvar gi = 0; gi < WINDOW_WIDTH; gi++) begin : g_tap
    if (gi == WINDOW_WIDTH - 1) begin : g_newest
      assign shifted[gi] = shift_in;
    end else begin : g_older
      assign shifted[gi] = taps_reg[gi+1];
    end
    assign kernel_o[gi] = ONE;
  end

  // ready_en_reg keeps ready low while reset is asserted.
  assign pix_ready_o = ready_en_reg && has_credit && (state_reg != ST_FLUSH);
  assign accept      = pix_valid_i && pix_ready_o;

  always_comb begin
    state_next   = state_reg;
    taps_next    = taps_reg;
    in_col_next  = in_col_reg;
    out_col_next = out_col_reg;
    row_next     = row_reg;
    issue        = 1'b0;
    frame_end    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          for (int i = 0; i < WINDOW_WIDTH; i++) taps_next[i] = left_pad;
          taps_next[WINDOW_WIDTH-1] = pix_i;
          in_col_next = 16'd1;
          state_next  = ST_FILL;
        end
      end
      ST_FILL: begin
        if (accept) begin
          taps_next   = shifted;
          in_col_next = in_col_reg + 16'd1;
          // pixel HALF completes the first centred window (col 0)
          if (in_col_reg == HALF_COL) begin
            issue        = 1'b1;
            out_col_next = 16'd1;
            state_next   = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (accept) begin
          taps_next    = shifted;
          issue        = 1'b1;
          out_col_next = out_col_reg + 16'd1;
          if (in_col_reg == LAST_COL) begin
            in_col_next = '0;
            state_next  = ST_FLUSH;
          end else begin
            in_col_next = in_col_reg + 16'd1;
          end
        end
      end
      ST_FLUSH: begin
        // without credit, hold taps and counters so nothing is duplicated
        if (has_credit) begin
          taps_next = shifted;
          issue     = 1'b1;
          if (out_col_reg == LAST_COL) begin
            out_col_next = '0;
            state_next   = ST_IDLE;
            if (row_reg == LAST_ROW) begin
              row_next  = '0;
              frame_end = 1'b1;
            end else begin
              row_next = row_reg + 16'd1;
            end
          end else begin
            out_col_next = out_col_reg + 16'd1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg      <= ST_IDLE;
      taps_reg       <= '0;
      in_col_reg     <= '0;
      out_col_reg    <= '0;
      row_reg        <= '0;
      col_out_reg    <= '0;
      row_out_reg    <= '0;
      valid_reg      <= 1'b0;
      frame_done_reg <= 1'b0;
      ready_en_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      taps_reg       <= taps_next;
      in_col_reg     <= in_col_next;
      out_col_reg    <= out_col_next;
      row_reg        <= row_next;
      valid_reg      <= issue;
      frame_done_reg <= frame_end;
      ready_en_reg   <= 1'b1;
      if (issue) begin
        col_out_reg <= out_col_reg;
        row_out_reg <= row_reg;
      end
    end
  end

  hwin_credit_counter #(
    .CREDITS (CREDITS)
  ) u_credit (
    .clk        (clk_i),
    .rst_n      (rst_ni),
    .inc        (credit_i),
    .dec        (issue),
    .has_credit (has_credit)
  );

  assign window_o     = taps_reg;
  assign col_o        = col_out_reg;
  assign row_o        = row_out_reg;
  assign valid_o      = valid_reg;
  assign frame_done_o = frame_done_reg;

endmodule

// File: tb/tb_hwin_sequencer_fp16.sv
// ---------------------------------------------------------------------------
// tb_hwin_sequencer_fp16
// Directed bench for hwin_sequencer_fp16 with an 8-pixel row and 7 taps.
// Instance a: 2-row frame, 16 credits, credits returned one cycle after
// each window. Instance b: 2 credits, credits returned by hand.
// Expected pad behaviour follows HWIN_REPLICATE_EDGE_EN as built.
// ---------------------------------------------------------------------------
module tb_hwin_sequencer_fp16;

  localparam int TAPS = 7;
  localparam int HALF = 3;
  localparam int IW   = 8;

`ifdef HWIN_REPLICATE_EDGE_EN
  localparam bit REPL = 1'b1;
`else
  localparam bit REPL = 1'b0;
`endif

  typedef logic [TAPS-1:0][15:0] win_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance a
  logic        rst_a, pv_a, ready_a, credit_a, vo_a, fd_a;
  logic [15:0] pix_a, col_a, row_a;
  win_t        win_a, kern_a;
  // instance b
  logic        rst_b, pv_b, ready_b, credit_b, vo_b, fd_b;
  logic [15:0] pix_b, col_b, row_b;
  win_t        win_b, kern_b;

  hwin_sequencer_fp16 #(
    .WINDOW_WIDTH (TAPS), .IMG_WIDTH (IW), .IMG_HEIGHT (2), .CREDITS (16)
  ) u_a (
    .clk_i (clk), .rst_ni (rst_a), .pix_i (pix_a), .pix_valid_i (pv_a),
    .pix_ready_o (ready_a), .credit_i (credit_a), .window_o (win_a),
    .kernel_o (kern_a), .col_o (col_a), .row_o (row_a), .valid_o (vo_a),
    .frame_done_o (fd_a)
  );

  hwin_sequencer_fp16 #(
    .WINDOW_WIDTH (TAPS), .IMG_WIDTH (IW), .IMG_HEIGHT (2), .CREDITS (2)
  ) u_b (
    .clk_i (clk), .rst_ni (rst_b), .pix_i (pix_b), .pix_valid_i (pv_b),
    .pix_ready_o (ready_b), .credit_i (credit_b), .window_o (win_b),
    .kernel_o (kern_b), .col_o (col_b), .row_o (row_b), .valid_o (vo_b),
    .frame_done_o (fd_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  logic [15:0] ramp [IW];
  logic [15:0] frame_pix [3][IW];

  // Reference window: tap j of column c is pixel c-HALF+j, or the pad.
  function automatic win_t exp_win(input logic [15:0] p [IW], input int c);
    win_t w;
    int k;
    for (int j = 0; j < TAPS; j++) begin
      k = c - HALF + j;
      if (k < 0)        w[j] = REPL ? p[0] : 16'h0000;
      else if (k >= IW) w[j] = REPL ? p[IW-1] : 16'h0000;
      else              w[j] = p[k];
    end
    return w;
  endfunction

  // capture of issued windows, plus credit return for instance a
  win_t        cap_win_a [64];
  logic [15:0] cap_col_a [64], cap_row_a [64];
  logic        cap_fd_a  [64];
  int          n_cap_a = 0, n_fd_a = 0;
  win_t        cap_win_b [16];
  logic [15:0] cap_col_b [16], cap_row_b [16];
  int          n_cap_b = 0, n_fd_b = 0;

  initial begin
    credit_a = 1'b0;
    forever begin
      @(negedge clk);
      credit_a = vo_a && rst_a;
      if (fd_a) n_fd_a++;
      if (fd_b) n_fd_b++;
      if (vo_a && n_cap_a < 64) begin
        cap_win_a[n_cap_a] = win_a;
        cap_col_a[n_cap_a] = col_a;
        cap_row_a[n_cap_a] = row_a;
        cap_fd_a[n_cap_a]  = fd_a;
        n_cap_a++;
      end
      if (vo_b && n_cap_b < 16) begin
        cap_win_b[n_cap_b] = win_b;
        cap_col_b[n_cap_b] = col_b;
        cap_row_b[n_cap_b] = row_b;
        n_cap_b++;
      end
    end
  end

  // Offer one pixel to a, starting and ending on a falling edge.
  task automatic send_a(input logic [15:0] p, output int waited);
    waited = 0;
    pix_a = p;
    pv_a  = 1'b1;
    while (!ready_a && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!ready_a) check("a_ready_timeout", {127'b0, ready_a}, 128'd1);
    else @(negedge clk);
    pv_a = 1'b0;
  endtask

  int idx_b;
  task automatic run_b(input int cycles);
    logic acc;
    for (int i = 0; i < cycles; i++) begin
      pv_b  = (idx_b < IW);
      pix_b = (idx_b < IW) ? ramp[idx_b] : 16'h0000;
      acc   = pv_b && ready_b;
      @(negedge clk);
      if (acc) idx_b++;
    end
    pv_b = 1'b0;
  endtask

  task automatic pulse_b();
    credit_b = 1'b1;
    @(negedge clk);
    credit_b = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  win_t hand_r0c0, hand_r0c7, hand_r1c0, hand_r1c7;
  int   waited, base, r, c;

  initial begin
    ramp = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600, 16'h4700, 16'h4800};
    for (int i = 0; i < IW; i++) begin
      frame_pix[0][i] = 16'h3C00;
      frame_pix[1][i] = ramp[i];
      frame_pix[2][i] = 16'h3C00;
    end
`ifdef HWIN_REPLICATE_EDGE_EN
    hand_r0c0 = {7{16'h3C00}};
    hand_r0c7 = {7{16'h3C00}};
    hand_r1c0 = {16'h4400, 16'h4200, 16'h4000, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00};
    hand_r1c7 = {16'h4800, 16'h4800, 16'h4800, 16'h4800, 16'h4700, 16'h4600, 16'h4500};
`else
    hand_r0c0 = {16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h0000, 16'h0000, 16'h0000};
    hand_r0c7 = {16'h0000, 16'h0000, 16'h0000, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00};
    hand_r1c0 = {16'h4400, 16'h4200, 16'h4000, 16'h3C00, 16'h0000, 16'h0000, 16'h0000};
    hand_r1c7 = {16'h0000, 16'h0000, 16'h0000, 16'h4800, 16'h4700, 16'h4600, 16'h4500};
`endif

    rst_a = 1'b0; pv_a = 1'b0; pix_a = '0;
    rst_b = 1'b0; pv_b = 1'b0; pix_b = '0; credit_b = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_ready",   {127'b0, ready_a}, 128'd0);
    check("rst_valid",   {127'b0, vo_a}, 128'd0);
    check("rst_fdone",   {127'b0, fd_a}, 128'd0);
    check("rst_col",     128'(col_a), 128'd0);
    check("rst_row",     128'(row_a), 128'd0);
    check("rst_window",  128'(win_a), 128'd0);
    check("rst_credits", 128'(u_a.u_credit.count_reg), 128'd16);
    check("kernel",      128'(kern_a), 128'({7{16'h3C00}}));
    rst_a = 1'b1;
    rst_b = 1'b1;
    @(negedge clk);
    check("ready_after_rst", {127'b0, ready_a}, 128'd1);

    // three back-to-back rows: frame rows 0,1 then row 0 of the next frame
    for (int rr = 0; rr < 3; rr++) begin
      for (int i = 0; i < IW; i++) begin
        send_a(frame_pix[rr][i], waited);
        if (rr > 0 && i == 0)
          check($sformatf("flush_gap_row%0d", rr), 128'(waited), 128'(HALF));
      end
    end
    repeat (10) @(negedge clk);

    check("a_window_count", 128'(n_cap_a), 128'd24);
    check("a_fdone_pulses", 128'(n_fd_a), 128'd1);
    for (int k = 0; k < 24 && k < n_cap_a; k++) begin
      r = k / IW;
      c = k % IW;
      $display("win %0d: row %0d col %0d fd %0d taps %h",
               k, cap_row_a[k], cap_col_a[k], cap_fd_a[k], cap_win_a[k]);
      check($sformatf("a_win%0d", k), 128'(cap_win_a[k]), 128'(exp_win(frame_pix[r], c)));
      check($sformatf("a_col%0d", k), 128'(cap_col_a[k]), 128'(c));
      check($sformatf("a_row%0d", k), 128'(cap_row_a[k]), 128'((r == 1) ? 1 : 0));
      check($sformatf("a_fd%0d", k),  {127'b0, cap_fd_a[k]}, 128'((k == 15) ? 1 : 0));
    end
    check("hand_r0c0", 128'(cap_win_a[0]),  128'(hand_r0c0));
    check("hand_r0c7", 128'(cap_win_a[7]),  128'(hand_r0c7));
    check("hand_r1c0", 128'(cap_win_a[8]),  128'(hand_r1c0));
    check("hand_r1c7", 128'(cap_win_a[15]), 128'(hand_r1c7));

    // reset in the middle of a row
    for (int i = 0; i < 5; i++) send_a(ramp[i], waited);
    rst_a = 1'b0;
    #1;
    check("midrst_valid",   {127'b0, vo_a}, 128'd0);
    check("midrst_credits", 128'(u_a.u_credit.count_reg), 128'd16);
    check("midrst_window",  128'(win_a), 128'd0);
    repeat (2) @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    base = n_cap_a;
    for (int i = 0; i < IW; i++) send_a(ramp[i], waited);
    repeat (10) @(negedge clk);
    check("post_rst_count", 128'(n_cap_a - base), 128'd8);
    check("post_rst_col0",  128'(cap_col_a[base]), 128'd0);
    check("post_rst_row0",  128'(cap_row_a[base]), 128'd0);
    check("post_rst_win0",  128'(cap_win_a[base]), 128'(exp_win(ramp, 0)));
    check("post_rst_col7",  128'(cap_col_a[base+7]), 128'd7);

    // credit starvation on instance b
    idx_b = 0;
    run_b(20);
    check("b_starved_count",   128'(n_cap_b), 128'd2);
    check("b_starved_ready",   {127'b0, ready_b}, 128'd0);
    check("b_starved_credits", 128'(u_b.u_credit.count_reg), 128'd0);
    pulse_b();
    run_b(10);
    check("b_one_credit_count", 128'(n_cap_b), 128'd3);
    for (int p = 0; p < 5; p++) begin
      pulse_b();
      run_b(8);
    end
    check("b_total_count", 128'(n_cap_b), 128'd8);
    check("b_fdone_pulses", 128'(n_fd_b), 128'd0);
    check("b_kernel", 128'(kern_b), 128'({7{16'h3C00}}));
    for (int k = 0; k < 8 && k < n_cap_b; k++) begin
      $display("bwin %0d: row %0d col %0d taps %h", k, cap_row_b[k], cap_col_b[k], cap_win_b[k]);
      check($sformatf("b_col%0d", k), 128'(cap_col_b[k]), 128'(k));
      check($sformatf("b_row%0d", k), 128'(cap_row_b[k]), 128'd0);
      check($sformatf("b_win%0d", k), 128'(cap_win_b[k]), 128'(exp_win(ramp, k)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hwin_sequencer_fp16.md
# hwin_sequencer_fp16

Raster-order scheduler that feeds the 1x7 horizontal fp16 box/convolution stage. Accepts one pixel per cycle over a valid/ready stream, keeps a 7-tap sliding window, pads row edges, and issues centred windows with col/row tags and valid to the convolution datapath. Downstream flow control uses credits, because the convolution pipeline has fixed latency and no stall input. Sits between the line reader and the convolution wrapper in the dfdd pipeline.

## Interface
- EXP_WIDTH, 5, fp exponent bits
- FRAC_WIDTH, 10, fp fraction bits
- WINDOW_WIDTH, 7, taps; odd, ≥3; HALF = WINDOW_WIDTH/2
- IMG_WIDTH, 640, pixels per row; ≥ WINDOW_WIDTH
- IMG_HEIGHT, 480, rows per frame
- CREDITS, 16, downstream slots; counter width $clog2(CREDITS+1)
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- pix_i  in  FP_WIDTH  input pixel, FP_WIDTH = 1+EXP_WIDTH+FRAC_WIDTH
- pix_valid_i  in  1  pixel offered
- pix_ready_o  out  1  pixel accepted when valid&ready
- credit_i  in  1  one-cycle pulse: one downstream slot freed
- window_o  out  FP_WIDTH x [1][WINDOW_WIDTH]  index 0 = leftmost (col c-HALF)
- kernel_o  out  FP_WIDTH x [1][WINDOW_WIDTH]  constant fp 1.0 (16'h3C00 at default)
- col_o, row_o  out  16 each  centre coordinate of window_o
- valid_o  out  1  window issued this cycle
- frame_done_o  out  1  one-cycle pulse with last window of frame

## Operation
- States: IDLE, FILL, RUN, FLUSH.
- IDLE: ready=1 if credits>0. First accepted pixel of a row: every entry loaded with pad, newest entry = pixel, in_col=1 -> FILL.
- FILL: shift in accepted pixels; when in_col reaches HALF+1 (pixel HALF accepted) -> RUN and issue window for col 0 in the same transition.
- RUN: each accepted pixel shifts in and issues a window, out_col = in_col-HALF. Accepting pixel IMG_WIDTH-1 -> FLUSH.
- FLUSH: pix_ready_o=0; each cycle with credits>0 shift in pad and issue one window; after HALF windows (out_col = IMG_WIDTH-1) advance row -> IDLE. After the last row, pulse frame_done_o and wrap row to 0.
- Pad value: see Configuration.
- Issue rule: window issued only when credits>0; pix_ready_o = credits>0 && state!=FLUSH. In IDLE/FILL an accept issues nothing, so credit is not needed, but ready is still gated for simplicity.
- Credits: -1 per valid_o, +1 per credit_i, unchanged when both in one cycle. credit_i while at CREDITS saturates; this is an error, flagged by assertion.
- Counters in_col/out_col/row are 16-bit, compared against IMG_WIDTH-1/IMG_HEIGHT-1, and wrap to 0.

## Timing
- Registered outputs. valid_o/window_o/col_o/row_o appear the cycle after the accepting handshake (RUN) or the FLUSH step.
- Row of W pixels yields exactly W windows; the last one appears HALF+1 cycles after the last accept when credits are available.
- Per-row overhead: HALF cycles of ready=0 (FLUSH).
- Reset values: state IDLE, credits=CREDITS, counters 0, window_o all 0, valid_o=0, frame_done_o=0, col_o=row_o=0, pix_ready_o=0 during reset and 1 from the first cycle after release.
- Reset mid-row discards the partial row; no window is issued for it.
- Credits hitting 0 mid-FLUSH: hold state and window; resume with no duplicates.

## Configuration
- HWIN_REPLICATE_EDGE_EN defined: pad = nearest edge pixel (first pixel of row on the left, last pixel on the right).
- Undefined: pad = fp +0.0 (all zeros).

## Structure
- Shared package dfdd_pkg: FP_WIDTH-derived fp16 typedef, FP_ONE constant, seq_state_t enum.
- One sub-module hwin_credit_counter (up/down saturating counter, has_credit output). Shift register and FSM stay in the top module.

## Test plan
- IMG_WIDTH=8, 1 row of 16'h3C00, replicate on -> 8 windows, all taps 3C00, col 0..7, row 0; ready low 3 cycles after the 8th accept.
- Same row with the macro off -> col0 window {0,0,0,3C00,3C00,3C00,3C00}; col7 window {3C00 x4, 0,0,0}.
- Pixels 1..8 (fp), replicate -> col0 = {1,1,1,1,2,3,4}, col7 = {5,6,7,8,8,8,8}.
- CREDITS=2, no credit_i -> exactly 2 valid_o, then ready=0; one credit_i pulse -> exactly 1 more window.
- IMG_HEIGHT=2, back-to-back rows -> row_o 0 then 1, frame_done_o coincides with (col7,row1), row wraps to 0.
- rst_ni low after 5 pixels of a row -> valid_o=0 and credits=CREDITS immediately; the next row starts at col 0, row 0.
